// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: reset/lock controller for the two-output system PLL.
// Holds the PLL in reset, waits for a synchronized lock, qualifies it for a
// programmable number of refclk cycles, and only then releases the system
// reset request. A lock timeout retries the PLL reset up to MAX_RETRIES times
// before parking in FAIL. relock_req restarts the sequence from any state.
// Optional macro PLL_SEQ_LOSS_CNT_EN adds the loss_cnt output, a saturating
// count of RUN exits caused by lock loss.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       relock_req,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       lock_err,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_o
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  state_t           state_r;
  state_t           next_state;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] next_cnt;
  logic [1:0]       next_retry;
  logic             sync_meta;
  logic             lk_s;
  logic             next_pll_rst;
  logic             next_sys_rst_n;
  logic             next_ready;
  logic             next_lock_err;

  assign state_o = state_r;

  // Two-flop synchronizer bringing the asynchronous PLL lock into refclk.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      lk_s      <= 1'b0;
    end else begin
      sync_meta <= pll_locked;
      lk_s      <= sync_meta;
    end
  end

  // Next-state, counter and retry logic; relock_req overrides everything.
  always_comb begin
    next_state = state_r;
    next_cnt   = cnt_r;
    next_retry = retry_cnt;
    if (relock_req) begin
      next_state = RST_PLL;
      next_cnt   = {CNT_W{1'b0}};
      next_retry = 2'd0;
    end else begin
      case (state_r)
        RST_PLL: begin
          if (cnt_r == RST_LAST) begin
            next_state = WAIT_LOCK;
            next_cnt   = {CNT_W{1'b0}};
          end else begin
            next_cnt = cnt_r + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lk_s) begin
            next_state = STABLE;
            next_cnt   = {CNT_W{1'b0}};
          end else if (cnt_r == TO_LAST) begin
            next_cnt = {CNT_W{1'b0}};
            if (retry_cnt < RETRY_MAX) begin
              next_retry = retry_cnt + 2'd1;
              next_state = RST_PLL;
            end else begin
              next_state = FAIL;
            end
          end else begin
            next_cnt = cnt_r + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!lk_s) begin
            // A captured low restarts qualification without spending a retry.
            next_state = WAIT_LOCK;
            next_cnt   = {CNT_W{1'b0}};
          end else if (cnt_r == STABLE_LAST) begin
            next_state = RUN;
            next_cnt   = {CNT_W{1'b0}};
            next_retry = 2'd0;
          end else begin
            next_cnt = cnt_r + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lk_s) begin
            next_state = RST_PLL;
            next_cnt   = {CNT_W{1'b0}};
          end else begin
            next_cnt = {CNT_W{1'b0}};
          end
        end
        FAIL: begin
          next_cnt = {CNT_W{1'b0}};
        end
        default: begin
          next_state = RST_PLL;
          next_cnt   = {CNT_W{1'b0}};
          next_retry = 2'd0;
        end
      endcase
    end
  end

  // Moore output decode from the next state so outputs register with the state.
  always_comb begin
    next_pll_rst   = 1'b0;
    next_sys_rst_n = 1'b0;
    next_ready     = 1'b0;
    next_lock_err  = 1'b0;
    case (next_state)
      RST_PLL:   next_pll_rst = 1'b1;
      WAIT_LOCK: next_pll_rst = 1'b0;
      STABLE:    next_pll_rst = 1'b0;
      RUN: begin
        next_sys_rst_n = 1'b1;
        next_ready     = 1'b1;
      end
      FAIL: begin
        next_pll_rst  = 1'b1;
        next_lock_err = 1'b1;
      end
      default: next_pll_rst = 1'b1;
    endcase
  end

  // State, counter, retry count and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RST_PLL;
      cnt_r     <= {CNT_W{1'b0}};
      retry_cnt <= 2'd0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      lock_err  <= 1'b0;
    end else begin
      state_r   <= next_state;
      cnt_r     <= next_cnt;
      retry_cnt <= next_retry;
      pll_rst   <= next_pll_rst;
      sys_rst_n <= next_sys_rst_n;
      ready     <= next_ready;
      lock_err  <= next_lock_err;
    end
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  // Saturating count of RUN exits caused by lock loss (relock_req excluded).
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= 8'd0;
    end else if ((state_r == RUN) && !lk_s && !relock_req && (loss_cnt != 8'd255)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end else begin
      loss_cnt <= loss_cnt;
    end
  end
`endif

endmodule
